// File: rtl/bus_sched_pkg.sv
// Shared definitions for the bus segment controllers.
//   state_e   : scheduler FSM states
//   ID_W      : width of the destination ID field at the packet MSBs
//   get_dest  : extracts the destination ID from a packet of any width
//               (packet zero-extended to PKT_MAX_W, msb = packet width - 1)
package bus_sched_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 1024;
  localparam int PKT_IDX_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    POP,
    ROUTE,
    PUSH,
    DROP
  } state_e;

  // The ID always sits in the top ID_W bits of the real packet, so the
  // caller passes the packet's own MSB index rather than a fixed width.
  function automatic logic [ID_W-1:0] get_dest(
    input logic [PKT_MAX_W-1:0] pkt,
    input logic [PKT_IDX_W-1:0] msb
  );
    return pkt[msb -: ID_W];
  endfunction

endpackage

// File: rtl/bus_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req      in   N     request vector
//   last_gnt in   IW    index granted last time; search starts one above it
//   valid    out  1     at least one request present
//   index    out  IW    first requesting index after last_gnt, wrapping mod N
// The wrap is done with an explicit modulo so N need not be a power of two
// and an index >= N can never be produced.
module rr_pick #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_gnt,
  output logic          valid,
  output logic [IW-1:0] index
);

  int unsigned base;
  int unsigned cand;

  // Walk the N candidates in priority order; the first hit wins and
  // later hits are ignored through the valid flag.
  always_comb begin
    valid = 1'b0;
    index = '0;
    base  = 32'(last_gnt);
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (base + 32'(k)) % 32'(N);
      if (!valid && (((req >> cand) & N'(1)) != '0)) begin
        valid = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_rr_sched.sv
// bus_rr_sched: round-robin scheduler and router for one shared bus segment.
// Picks a pending driver FIFO fairly, pops one packet, decodes the destination
// ID in its MSBs and pushes it to the target receiver, to every driver except
// the source on broadcast, or drops it (with err and drop_cnt) if invalid.
//   clk       in   1               rising-edge clock
//   reset     in   1               synchronous active-high reset
//   pndng     in   drvrs           per-driver FIFO not-empty
//   D_pop     in   drvrs*pckg_sz   per-driver FIFO head, driver i at [i*pckg_sz +: pckg_sz]
//   pop       out  drvrs           one-hot pop strobe
//   push      out  drvrs           receiver push mask, 1 cycle
//   D_push    out  pckg_sz         packet on the bus, holds last value when push=0
//   gnt_id    out  GW              currently/last granted source
//   busy      out  1               FSM not idle
//   err       out  1               1-cycle pulse on a dropped packet
//   pkt_cnt   out  CNT_W           delivered packets, saturating
//   drop_cnt  out  CNT_W           dropped packets, saturating
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int              drvrs     = 6,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF,
  parameter int              CNT_W     = 8,
  parameter int              GW        = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  output logic [GW-1:0]            gnt_id,
  output logic                     busy,
  output logic                     err,
  output logic [CNT_W-1:0]         pkt_cnt,
  output logic [CNT_W-1:0]         drop_cnt
);

  state_e             state;
  state_e             state_nxt;
  logic [GW-1:0]      last_gnt;
  logic [pckg_sz-1:0] pkt;
  logic               pick_valid;
  logic [GW-1:0]      pick_idx;
  logic [drvrs-1:0]   gnt_onehot;
  logic               pop_ok;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    dest;
  logic               route_ok;
  logic [drvrs-1:0]   route_mask;

  rr_pick #(
    .N  (drvrs),
    .IW (GW)
  ) u_pick (
    .req      (pndng),
    .last_gnt (last_gnt),
    .valid    (pick_valid),
    .index    (pick_idx)
  );

  assign gnt_onehot = drvrs'(1) << gnt_id;
  assign pop_ok     = |(pndng & gnt_onehot);
  assign head       = pckg_sz'(D_pop >> (32'(gnt_id) * 32'(pckg_sz)));
  assign busy       = (state != IDLE);

  // Destination decode for the packet captured in POP. Broadcast is tested
  // first because its ID lies outside the driver range.
  always_comb begin
    dest       = get_dest(PKT_MAX_W'(pkt), PKT_IDX_W'(pckg_sz - 1));
    route_ok   = 1'b0;
    route_mask = '0;
    if (dest == broadcast) begin
      route_ok   = 1'b1;
      route_mask = ~gnt_onehot;
    end else if ((32'(dest) < 32'(drvrs)) && (32'(dest) != 32'(gnt_id))) begin
      route_ok   = 1'b1;
      route_mask = drvrs'(1) << dest;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the pop strobe. pop is decoded from the state
  // register but qualified by the live pndng bit, so a FIFO that emptied
  // between GRANT and POP is never popped and the transfer aborts.
  always_comb begin
    state_nxt = state;
    pop       = '0;
    case (state)
      IDLE: begin
        if (|pndng) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = pick_valid ? POP : IDLE;
      end
      POP: begin
        if (pop_ok) begin
          pop       = gnt_onehot;
          state_nxt = ROUTE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ROUTE: begin
        state_nxt = route_ok ? PUSH : DROP;
      end
      PUSH, DROP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: grant capture, packet capture, and the registered push/err
  // pulses which are loaded on the edge leaving ROUTE so they are visible
  // exactly in the PUSH or DROP cycle. Counters step on that same edge.
  // last_gnt only moves on a real pop, so aborted grants keep fairness.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= GW'(drvrs - 1);
      gnt_id   <= '0;
      pkt      <= '0;
      push     <= '0;
      D_push   <= '0;
      err      <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      push <= '0;
      err  <= 1'b0;
      case (state)
        GRANT: begin
          if (pick_valid) begin
            gnt_id <= pick_idx;
          end
        end
        POP: begin
          if (pop_ok) begin
            pkt      <= head;
            last_gnt <= gnt_id;
          end
        end
        ROUTE: begin
          if (route_ok) begin
            push   <= route_mask;
            D_push <= pkt;
            if (pkt_cnt != '1) begin
              pkt_cnt <= pkt_cnt + 1'b1;
            end
          end else begin
            err <= 1'b1;
            if (drop_cnt != '1) begin
              drop_cnt <= drop_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
